sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 18, SRAM address width.
REQ-002 Parameter ACCESS_CYCLES, default 2, strobe width in clk cycles; legal range 1..15.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 n_reset  in  1  synchronous active-low reset.
REQ-005 a_req / b_req  in  1  port A (CPU) / port B (loader/DMA) access request.
REQ-006 a_we / b_we  in  1  1 = write, 0 = read.
REQ-007 a_addr / b_addr  in  ADDR_W  access address.
REQ-008 a_wdata / b_wdata  in  8  write data.
REQ-009 a_ack / b_ack  out  1  one-cycle completion pulse.
REQ-010 a_rdata / b_rdata  out  8  read data; valid with ack; held until that port's next read ack.
REQ-011 sram_addr  out  ADDR_W  SRAM address.
REQ-012 sram_dout  out  8  SRAM write data.
REQ-013 sram_din  in  8  SRAM read data from pad.
REQ-014 sram_drive  out  1  pad output enable; 1 drives sram_dout.
REQ-015 n_sram_cs / n_sram_oe / n_sram_we  out  1  active-low SRAM strobes.
REQ-016 grant_b  out  1  high while port B owns the current access.

Function
REQ-017 States IDLE, SETUP, ACCESS, HOLD; IDLE->SETUP when any req is sampled high; SETUP->ACCESS after 1 cycle; ACCESS->HOLD after ACCESS_CYCLES cycles; HOLD->IDLE after 1 cycle.
REQ-018 Requester holds req, we, addr, wdata stable from assertion until ack; arbiter registers the granted port's fields on the IDLE->SETUP edge and ignores later input changes.
REQ-019 req still high in the cycle after ack is a new request.
REQ-020 Arbitration in IDLE only: A alone -> A; B alone -> B; both -> per Configuration.
REQ-021 n_sram_cs low in SETUP, ACCESS, HOLD; high in IDLE.
REQ-022 Write: sram_drive high SETUP..HOLD; n_sram_we low only in ACCESS; n_sram_oe high throughout.
REQ-023 Read: n_sram_oe low SETUP..ACCESS; sram_drive low; sram_din captured into the granted port's rdata on the final ACCESS cycle.
REQ-024 ack pulses for the granted port in the HOLD cycle; latency from req sampled in IDLE to ack = ACCESS_CYCLES+2 cycles (4 at default).
REQ-025 No idle gap is required: a request sampled in the IDLE cycle following HOLD starts SETUP on the next edge.
REQ-026 Write and read never overlap: n_sram_we and n_sram_oe are never low in the same cycle.
REQ-027 The ACCESS counter width is 4 bits; it reloads on entry to ACCESS and never wraps mid-access.

Reset
REQ-028 On n_reset low at a clk edge: state IDLE, n_sram_cs/oe/we = 1, sram_drive = 0, sram_addr = 0, sram_dout = 0, a/b_ack = 0, a/b_rdata = 0x00, grant_b = 0, last-grant = B.
REQ-029 Reset mid-access aborts immediately: strobes deassert at that edge, no ack is issued, and the pending request is re-arbitrated after reset release.

Configuration
REQ-030 Macro SRAM_ARB_RR_EN defined: round-robin; on contention, grant goes to the port not granted last; after reset A wins first contention.
REQ-031 SRAM_ARB_RR_EN undefined: fixed priority; A always wins contention; the last-grant register is not built.

Structure
REQ-032 Package sram_arbiter_pkg holds the state enum, port index constants (PORT_A=0, PORT_B=1), and default ACCESS_CYCLES.
REQ-033 One sub-module, sram_arb_pick: combinational grant selection from a_req, b_req, and last-grant; contains the SRAM_ARB_RR_EN ifdef.

Verification
REQ-034 A writes 0x5A to 0x00123 alone -> n_sram_we low exactly 2 cycles, sram_drive covers SETUP..HOLD, a_ack at cycle 4.
REQ-035 B reads 0x3FFFF with sram_din=0xC3 -> b_rdata=0xC3 with b_ack at cycle 4; n_sram_oe low 3 cycles, n_sram_we never low.
REQ-036 A and B held high for 4 accesses, RR enabled -> grants A,B,A,B; RR disabled -> A,A,A,A with B acked only after a_req drops.
REQ-037 n_reset low during B write ACCESS -> all strobes high at that edge, no b_ack; after release, B is re-served with a full 4-cycle access.
REQ-038 ACCESS_CYCLES=1 and =15 -> ack latency 3 and 17 cycles; no cycle with n_sram_oe and n_sram_we both low.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port asynchronous SRAM arbiter.
//   arb_state_t           : access sequencer states
//   PORT_A / PORT_B       : grant encoding (also the last-grant encoding)
//   DEFAULT_ACCESS_CYCLES : default strobe width in clk cycles
//   CNT_W                 : width of the ACCESS-phase down counter
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int DEFAULT_ACCESS_CYCLES = 2;
  localparam int CNT_W = 4;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant selection between port A (CPU) and port B (loader/DMA).
// Build option: define SRAM_ARB_RR_EN for round-robin on contention; when it
// is undefined A always wins contention and the last_grant input does not exist.
//
// Ports:
//   a_req, b_req : raw requests from the two ports
//   last_grant   : port granted most recently (SRAM_ARB_RR_EN builds only)
//   any_req      : at least one port is requesting
//   pick         : PORT_A or PORT_B, meaningful only when any_req is high
module sram_arb_pick
  import sram_arbiter_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
`ifdef SRAM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic any_req,
  output logic pick
);

  always_comb begin
    any_req = a_req | b_req;
`ifdef SRAM_ARB_RR_EN
    // Contention goes to whichever port did not get the previous access.
    if (a_req && b_req) begin
      pick = (last_grant == PORT_A) ? PORT_B : PORT_A;
    end else begin
      pick = b_req ? PORT_B : PORT_A;
    end
`else
    pick = (b_req && !a_req) ? PORT_B : PORT_A;
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single 8-bit asynchronous SRAM.
// Each access runs IDLE -> SETUP -> ACCESS (ACCESS_CYCLES clocks) -> HOLD and
// acknowledges the granted port with a one-cycle pulse in HOLD.
// Build option: SRAM_ARB_RR_EN selects round-robin contention handling
// (default build: fixed priority, A wins).
//
// Handshake: a port raises req with we/addr/wdata and keeps all of them
// stable until its ack pulse; the fields are registered on the IDLE->SETUP
// edge. A req still high in the cycle after ack is a new request.
//
// Ports:
//   clk, n_reset            : clock, synchronous active-low reset
//   a_*/b_* req,we,addr,wdata : request side of ports A and B
//   a_ack/b_ack             : completion pulse (HOLD cycle)
//   a_rdata/b_rdata         : read data, updated with each read ack
//   sram_addr/dout/din      : SRAM address, write data, pad read data
//   sram_drive              : pad output enable for sram_dout
//   n_sram_cs/oe/we         : active-low SRAM strobes
//   grant_b                 : port B owns the current access
//   state_dbg               : current sequencer state (arb_state_t encoding)
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 18,
  parameter int ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES  // legal 1..15
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_wdata,
  output logic              a_ack,
  output logic [7:0]        a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_wdata,
  output logic              b_ack,
  output logic [7:0]        b_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dout,
  input  logic [7:0]        sram_din,
  output logic              sram_drive,
  output logic              n_sram_cs,
  output logic              n_sram_oe,
  output logic              n_sram_we,
  output logic              grant_b,
  output logic [1:0]        state_dbg
);

  // Counter reload: counts down to zero, so the last ACCESS cycle sees 0.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  arb_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              acc_we;     // registered direction of the current access
  logic              any_req;
  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_wdata;

`ifdef SRAM_ARB_RR_EN
  logic last_grant;
`endif

  sram_arb_pick u_pick (
    .a_req      (a_req),
    .b_req      (b_req),
`ifdef SRAM_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .any_req    (any_req),
    .pick       (pick)
  );

  always_comb begin
    sel_we    = a_we;
    sel_addr  = a_addr;
    sel_wdata = a_wdata;
    if (pick == PORT_B) begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end
  end

  assign state_dbg = state;

  // All strobes are registered and change on state transitions, so every
  // output is glitch-free and aligned with the state it belongs to.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      acc_we     <= 1'b0;
      n_sram_cs  <= 1'b1;
      n_sram_oe  <= 1'b1;
      n_sram_we  <= 1'b1;
      sram_drive <= 1'b0;
      sram_addr  <= '0;
      sram_dout  <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata    <= 8'h00;
      b_rdata    <= 8'h00;
      grant_b    <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_grant <= PORT_B;  // so A wins the first contention after reset
`endif
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= SETUP;
            grant_b    <= (pick == PORT_B);
            acc_we     <= sel_we;
            sram_addr  <= sel_addr;
            sram_dout  <= sel_wdata;
            n_sram_cs  <= 1'b0;
            sram_drive <= sel_we;
            n_sram_oe  <= sel_we;   // reads enable the output from SETUP
`ifdef SRAM_ARB_RR_EN
            last_grant <= pick;
`endif
          end
        end
        SETUP: begin
          state     <= ACCESS;
          cnt       <= CNT_LOAD;
          n_sram_we <= !acc_we;
        end
        ACCESS: begin
          if (cnt == '0) begin
            state     <= HOLD;
            n_sram_we <= 1'b1;
            n_sram_oe <= 1'b1;
            // Final ACCESS cycle: the pad data has settled for the full strobe.
            if (!acc_we) begin
              if (grant_b) b_rdata <= sram_din;
              else         a_rdata <= sram_din;
            end
            if (grant_b) b_ack <= 1'b1;
            else         a_ack <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          state      <= IDLE;
          n_sram_cs  <= 1'b1;
          sram_drive <= 1'b0;
          grant_b    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
